ceu_div_scheduler: RTL and testbench

//  Upstream request scheduler for the CEU double-precision divider. Queues divide

---
 rtl/ceu_div_scheduler_pkg.sv | 22 ++
 rtl/ceu_div_scheduler_if.sv | 37 +++
 rtl/ceu_div_scheduler_req_fifo.sv | 53 +++++
 rtl/ceu_div_scheduler.sv | 139 +++++++++++++
 tb/tb_ceu_div_scheduler.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ceu_div_scheduler_pkg.sv
// Shared types and IEEE-754 helpers for the CEU divide request scheduler.
package ceu_div_pkg;

  typedef enum logic [2:0] {
    S_DRAIN = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } sched_state_t;

  // Positive quiet NaN, returned for 0/0
  localparam logic [63:0] DBL_QNAN    = 64'h7FF8_0000_0000_0000;
  // Infinity without its sign bit; the sign is num[63]^den[63]
  localparam logic [62:0] DBL_INF_MAG = {11'h7FF, 52'h0};

  // True for +0.0 and -0.0 (sign bit ignored)
  function automatic logic is_dbl_zero(input logic [63:0] x);
    return (x[62:0] == 63'd0);
  endfunction

endpackage

// File: rtl/ceu_div_scheduler_if.sv
// Request, divider and result bus of the CEU divide scheduler.
// slave: the scheduler's view; master: the surrounding datapath/divider view.
interface ceu_div_scheduler_if #(
  parameter int DBL_WIDTH = 64,
  parameter int TAG_WIDTH = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic [DBL_WIDTH-1:0] req_num;
  logic [DBL_WIDTH-1:0] req_den;
  logic [TAG_WIDTH-1:0] req_tag;

  logic                 div_valid;
  logic [DBL_WIDTH-1:0] div_num;
  logic [DBL_WIDTH-1:0] div_den;
  logic                 div_finish;
  logic [DBL_WIDTH-1:0] div_quot;

  logic                 res_valid;
  logic                 res_ready;
  logic [DBL_WIDTH-1:0] res_quot;
  logic [TAG_WIDTH-1:0] res_tag;
  logic                 res_dz;

  logic                 busy;

  modport slave (
    input  req_valid, req_num, req_den, req_tag, div_finish, div_quot, res_ready,
    output req_ready, div_valid, div_num, div_den, res_valid, res_quot, res_tag, res_dz, busy
  );

  modport master (
    output req_valid, req_num, req_den, req_tag, div_finish, div_quot, res_ready,
    input  req_ready, div_valid, div_num, div_den, res_valid, res_quot, res_tag, res_dz, busy
  );

endinterface

// File: rtl/ceu_div_scheduler_req_fifo.sv
// Synchronous request FIFO for the divide scheduler. Push and pop in the same
// cycle are allowed even when full; occupancy is then unchanged.
module ceu_div_req_fifo #(
  parameter int WIDTH = 136,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // Pointers wrap modulo DEPTH; the counter alone decides full/empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale contents are unreachable once the FIFO is empty
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ceu_div_scheduler.sv
// Upstream scheduler for the CEU double-precision divider: queues tagged divide
// requests, issues one at a time, returns quotients in request order.
// Optional: define CEU_DIV_ZERO_CHECK_EN to answer x/0 locally (inf or qNaN,
// res_dz=1) without using the divider.
module ceu_div_scheduler #(
  parameter int DBL_WIDTH    = 64,
  parameter int TAG_WIDTH    = 4,
  parameter int DEPTH        = 8,
  parameter int DRAIN_CYCLES = 64
) (
  input logic               clk,
  input logic               rst_n,
  ceu_div_scheduler_if.slave bus
);
  import ceu_div_pkg::*;

  localparam int EW = TAG_WIDTH + 2*DBL_WIDTH;
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  sched_state_t         state;
  logic [CW-1:0]        drain_cnt;
  logic                 active;
  logic [DBL_WIDTH-1:0] num_q;
  logic [DBL_WIDTH-1:0] den_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 div_valid_q;
  logic                 res_valid_q;
  logic [DBL_WIDTH-1:0] res_quot_q;
  logic                 res_dz_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [EW-1:0]        fifo_rdata;
  logic [DBL_WIDTH-1:0] head_num;
  logic [DBL_WIDTH-1:0] head_den;
  logic [TAG_WIDTH-1:0] head_tag;
  logic                 bypass;
  logic [DBL_WIDTH-1:0] special_quot;

  assign fifo_push = bus.req_valid && bus.req_ready;
  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
  assign head_num  = fifo_rdata[DBL_WIDTH-1:0];
  assign head_den  = fifo_rdata[2*DBL_WIDTH-1:DBL_WIDTH];
  assign head_tag  = fifo_rdata[EW-1:2*DBL_WIDTH];

  ceu_div_req_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({bus.req_tag, bus.req_den, bus.req_num}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef CEU_DIV_ZERO_CHECK_EN
  assign bypass       = is_dbl_zero(head_den);
  assign special_quot = is_dbl_zero(head_num) ? DBL_QNAN
                                              : {head_num[63] ^ head_den[63], DBL_INF_MAG};
`else
  assign bypass       = 1'b0;
  assign special_quot = '0;
`endif

  // Low during reset and for the first edge after release so handshake outputs read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active <= 1'b0;
    else        active <= 1'b1;
  end

  // Single-outstanding issue FSM; div_valid is registered one cycle behind S_ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_DRAIN;
      drain_cnt   <= '0;
      num_q       <= '0;
      den_q       <= '0;
      tag_q       <= '0;
      div_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_quot_q  <= '0;
      res_dz_q    <= 1'b0;
    end else begin
      div_valid_q <= (state == S_ISSUE);
      case (state)
        S_DRAIN: begin
          if (drain_cnt == CW'(DRAIN_CYCLES)) state <= S_IDLE;
          else                                drain_cnt <= drain_cnt + CW'(1);
        end
        S_IDLE: begin
          if (!fifo_empty) begin
            num_q <= head_num;
            den_q <= head_den;
            tag_q <= head_tag;
            if (bypass) begin
              res_quot_q  <= special_quot;
              res_dz_q    <= 1'b1;
              res_valid_q <= 1'b1;
              state       <= S_OUT;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (bus.div_finish) begin
            res_quot_q  <= bus.div_quot;
            res_dz_q    <= 1'b0;
            res_valid_q <= 1'b1;
            state       <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            res_dz_q    <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_DRAIN;
      endcase
    end
  end

  assign bus.req_ready = active && !fifo_full;
  assign bus.busy      = active && (!fifo_empty || (state != S_IDLE));
  assign bus.div_valid = div_valid_q;
  assign bus.div_num   = num_q;
  assign bus.div_den   = den_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_quot  = res_quot_q;
  assign bus.res_tag   = tag_q;
  assign bus.res_dz    = res_dz_q;

endmodule

// File: tb/tb_ceu_div_scheduler.sv
// Directed bench for ceu_div_scheduler with a fixed 20-cycle divider model.
module tb_ceu_div_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ceu_div_scheduler_if #(.DBL_WIDTH(64), .TAG_WIDTH(4)) bus ();

  ceu_div_scheduler #(
    .DBL_WIDTH(64), .TAG_WIDTH(4), .DEPTH(8), .DRAIN_CYCLES(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          div_pulses = 0;
  logic        stale_finish = 1'b0;
  logic        model_finish;
  logic [63:0] model_quot;
  logic [63:0] op_num;
  logic [63:0] op_den;
  int          lat_cnt;
  logic [63:0] b2b_val [8];

  // Divider model: fixed 20-cycle latency, real-valued division
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt      <= 0;
      model_finish <= 1'b0;
    end else begin
      model_finish <= 1'b0;
      if (bus.div_valid) begin
        lat_cnt <= 20;
        op_num  <= bus.div_num;
        op_den  <= bus.div_den;
      end else if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) begin
          model_finish <= 1'b1;
          model_quot   <= $realtobits($bitstoreal(op_num) / $bitstoreal(op_den));
        end
      end
    end
  end

  assign bus.div_finish = model_finish | stale_finish;
  assign bus.div_quot   = model_finish ? model_quot : 64'hDEAD_BEEF_DEAD_BEEF;

  // Count issue pulses seen by the divider
  always @(posedge clk) begin
    if (bus.div_valid) div_pulses <= div_pulses + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [63:0] n, input logic [63:0] d, input logic [3:0] t);
    int guard = 0;
    while (!bus.req_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL push_timeout: req_ready=%b required 1 within 300 cycles", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_num   = n;
    bus.req_den   = d;
    bus.req_tag   = t;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, output logic [63:0] q,
                             output logic [3:0] t, output logic dz);
    int i = 0;
    while (!bus.res_valid && i < 200) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (bus.res_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s_timeout: res_valid=%b required 1 within 200 cycles", name, bus.res_valid);
    end
    q  = bus.res_quot;
    t  = bus.res_tag;
    dz = bus.res_dz;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.busy, bus.div_valid, bus.res_valid, bus.res_dz} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: rdy/busy/dv/rv/dz=%b expected 00000",
               {bus.req_ready, bus.busy, bus.div_valid, bus.res_valid, bus.res_dz});
    end
    n_checks++;
    if ({bus.res_quot, bus.res_tag, bus.div_num, bus.div_den} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: quot=%h tag=%h num=%h den=%h expected all 0",
               bus.res_quot, bus.res_tag, bus.div_num, bus.div_den);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.busy} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL reset_release: ready/busy=%b expected 11", {bus.req_ready, bus.busy});
    end
  endtask

  task automatic test_stale_finish();
    int i = 0;
    logic quiet_ok = 1'b1;
    logic [63:0] q; logic [3:0] t; logic dz;
    do_reset();
    repeat (2) @(negedge clk);
    stale_finish = 1'b1;
    @(negedge clk);
    stale_finish = 1'b0;
    while (bus.busy && i < 40) begin
      if (bus.res_valid) quiet_ok = 1'b0;
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stale_drain_end: busy=%b expected 0 after drain", bus.busy);
    end
    stale_finish = 1'b1;
    @(negedge clk);
    stale_finish = 1'b0;
    repeat (10) begin
      if (bus.res_valid || bus.busy) quiet_ok = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (quiet_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stale_ignored: spurious res_valid/busy=%b expected none", ~quiet_ok);
    end
    push(64'h3FF0_0000_0000_0000, 64'h4010_0000_0000_0000, 4'd9);
    wait_result("stale_next", q, t, dz);
    n_checks++;
    if (q !== 64'h3FD0_0000_0000_0000 || t !== 4'd9) begin
      n_fail++;
      $display("[TB] FAIL stale_next_result: quot=%h tag=%0d expected 3fd0000000000000 tag 9", q, t);
    end
  endtask

  task automatic test_single();
    int p0 = div_pulses;
    logic [63:0] q; logic [3:0] t; logic dz;
    push(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 4'd3);
    n_checks++;
    if (bus.div_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_early_e0: div_valid=%b expected 0", bus.div_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.div_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_early_e1: div_valid=%b expected 0", bus.div_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.div_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_issue_e2: div_valid=%b expected 1", bus.div_valid);
    end
    n_checks++;
    if (bus.div_num !== 64'h4018_0000_0000_0000 || bus.div_den !== 64'h4000_0000_0000_0000) begin
      n_fail++;
      $display("[TB] FAIL single_operands: num=%h den=%h expected 4018000000000000/4000000000000000",
               bus.div_num, bus.div_den);
    end
    @(negedge clk);
    n_checks++;
    if (bus.div_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_pulse_width: div_valid=%b expected 0", bus.div_valid);
    end
    wait_result("single", q, t, dz);
    n_checks++;
    if (q !== 64'h4008_0000_0000_0000 || t !== 4'd3 || dz !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_result: quot=%h tag=%0d dz=%b expected 4008000000000000 tag 3 dz 0",
               q, t, dz);
    end
    n_checks++;
    if (div_pulses - p0 !== 1) begin
      n_fail++;
      $display("[TB] FAIL single_pulse_count: pulses=%0d expected 1", div_pulses - p0);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    logic [63:0] q; logic [3:0] t; logic dz;
    b2b_val = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
                64'h4008_0000_0000_0000, 64'h4010_0000_0000_0000,
                64'h4014_0000_0000_0000, 64'h4018_0000_0000_0000,
                64'h401C_0000_0000_0000, 64'h4020_0000_0000_0000};
    do_reset();
    @(negedge clk);
    p0 = div_pulses;
    for (int k = 0; k < 8; k++) push(b2b_val[k], 64'h3FF0_0000_0000_0000, 4'(k));
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_full: req_ready=%b expected 0 after 8th push", bus.req_ready);
    end
    for (int k = 0; k < 8; k++) begin
      wait_result("b2b", q, t, dz);
      n_checks++;
      if (t !== 4'(k) || q !== b2b_val[k]) begin
        n_fail++;
        $display("[TB] FAIL b2b_result_%0d: tag=%0d quot=%h expected tag %0d quot %h",
                 k, t, q, k, b2b_val[k]);
      end
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (div_pulses - p0 !== 8) begin
      n_fail++;
      $display("[TB] FAIL b2b_pulse_count: pulses=%0d expected 8", div_pulses - p0);
    end
  endtask

  task automatic test_backpressure();
    int i = 0;
    int p0;
    logic stable_ok = 1'b1;
    logic [63:0] q; logic [3:0] t; logic dz;
    bus.res_ready = 1'b0;
    push(64'h4022_0000_0000_0000, 64'h4008_0000_0000_0000, 4'd5);
    push(64'h4024_0000_0000_0000, 64'h4010_0000_0000_0000, 4'd6);
    while (!bus.res_valid && i < 200) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (bus.res_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_timeout: res_valid=%b required 1", bus.res_valid);
    end
    p0 = div_pulses;
    repeat (30) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_quot !== 64'h4008_0000_0000_0000 || bus.res_tag !== 4'd5)
        stable_ok = 1'b0;
    end
    n_checks++;
    if (stable_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_hold: rv=%b quot=%h tag=%0d expected held 1/4008000000000000/5",
               bus.res_valid, bus.res_quot, bus.res_tag);
    end
    n_checks++;
    if (div_pulses !== p0) begin
      n_fail++;
      $display("[TB] FAIL bp_no_issue: pulses=%0d expected %0d while stalled", div_pulses, p0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_release: res_valid=%b expected 0 after handshake", bus.res_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.div_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_issue_early: div_valid=%b expected 0 one cycle after handshake", bus.div_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.div_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_issue: div_valid=%b expected 1 two cycles after handshake", bus.div_valid);
    end
    wait_result("bp_second", q, t, dz);
    n_checks++;
    if (q !== 64'h4004_0000_0000_0000 || t !== 4'd6) begin
      n_fail++;
      $display("[TB] FAIL bp_second_result: quot=%h tag=%0d expected 4004000000000000 tag 6", q, t);
    end
  endtask

  task automatic test_reset_mid();
    int i = 0;
    int p0 = div_pulses;
    logic quiet_ok = 1'b1;
    logic [63:0] q; logic [3:0] t; logic dz;
    for (int k = 0; k < 4; k++) push(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 4'(10 + k));
    while (div_pulses == p0 && i < 50) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.busy, bus.div_valid, bus.res_valid} !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_flags: rdy/busy/dv/rv=%b expected 0000",
               {bus.req_ready, bus.busy, bus.div_valid, bus.res_valid});
    end
    n_checks++;
    if (bus.div_num !== 64'h0 || bus.res_tag !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_data: num=%h tag=%0d expected 0", bus.div_num, bus.res_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    p0 = div_pulses;
    repeat (60) begin
      @(negedge clk);
      if (bus.res_valid || bus.div_valid) quiet_ok = 1'b0;
    end
    n_checks++;
    if (quiet_ok !== 1'b1 || div_pulses !== p0) begin
      n_fail++;
      $display("[TB] FAIL midreset_dropped: activity=%b pulses=%0d expected none/%0d",
               ~quiet_ok, div_pulses, p0);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_empty: busy=%b expected 0", bus.busy);
    end
    push(64'h401C_0000_0000_0000, 64'h4000_0000_0000_0000, 4'd1);
    wait_result("midreset_next", q, t, dz);
    n_checks++;
    if (q !== 64'h400C_0000_0000_0000 || t !== 4'd1) begin
      n_fail++;
      $display("[TB] FAIL midreset_next_result: quot=%h tag=%0d expected 400c000000000000 tag 1", q, t);
    end
  endtask

  task automatic test_zero_check();
    int p0 = div_pulses;
    logic [63:0] q; logic [3:0] t; logic dz;
    push(64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0000, 4'd2);
    wait_result("zero_inf", q, t, dz);
`ifdef CEU_DIV_ZERO_CHECK_EN
    n_checks++;
    if (q !== 64'h7FF0_0000_0000_0000 || dz !== 1'b1 || t !== 4'd2) begin
      n_fail++;
      $display("[TB] FAIL zero_inf: quot=%h dz=%b tag=%0d expected 7ff0000000000000 dz 1 tag 2", q, dz, t);
    end
    push(64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd4);
    wait_result("zero_nan", q, t, dz);
    n_checks++;
    if (q !== 64'h7FF8_0000_0000_0000 || dz !== 1'b1 || t !== 4'd4) begin
      n_fail++;
      $display("[TB] FAIL zero_nan: quot=%h dz=%b tag=%0d expected 7ff8000000000000 dz 1 tag 4", q, dz, t);
    end
    n_checks++;
    if (div_pulses !== p0) begin
      n_fail++;
      $display("[TB] FAIL zero_no_issue: pulses=%0d expected %0d", div_pulses, p0);
    end
`else
    n_checks++;
    if (q !== 64'h7FF0_0000_0000_0000 || dz !== 1'b0 || t !== 4'd2) begin
      n_fail++;
      $display("[TB] FAIL zero_through_div: quot=%h dz=%b tag=%0d expected 7ff0000000000000 dz 0 tag 2", q, dz, t);
    end
    n_checks++;
    if (div_pulses - p0 !== 1) begin
      n_fail++;
      $display("[TB] FAIL zero_issue_count: pulses=%0d expected 1", div_pulses - p0);
    end
`endif
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_num   = '0;
    bus.req_den   = '0;
    bus.req_tag   = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_stale_finish();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_zero_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
